// File: rtl/div_pkg.sv
// div_pkg: shared types and constants for the divisor scan sequencer.
// Select k tests divisor k+2.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_e;

    localparam logic [2:0] SEL_D2 = 3'd0;
    localparam logic [2:0] SEL_D3 = 3'd1;
    localparam logic [2:0] SEL_D4 = 3'd2;
    localparam logic [2:0] SEL_D5 = 3'd3;
    localparam logic [2:0] SEL_D6 = 3'd4;
    localparam logic [2:0] SEL_D7 = 3'd5;
    localparam logic [2:0] SEL_D8 = 3'd6;
    localparam logic [2:0] SEL_D9 = 3'd7;

    // odd A cannot divide by 4, 6, 8; A not a multiple of 3 cannot by 6, 9
    localparam logic [7:0] SKIP_IF_ODD  = 8'b0101_0100;
    localparam logic [7:0] SKIP_IF_NOT3 = 8'b1001_0000;

endpackage

// File: rtl/div_check.sv
// div_check: combinational 5-bit divisibility test.
// Powers of two report 1 for A=0, the other divisors report 0.
module div_check
    import div_pkg::*;
(
    input  logic [4:0] a_i,
    input  logic [2:0] sel_i,
    output logic       out_o
);

    logic nz;
    assign nz = (a_i != 5'd0);

    // Divisibility of a_i by the divisor chosen with sel_i
    always_comb begin
        out_o = 1'b0;
        case (sel_i)
            SEL_D2:  out_o = (a_i[0] == 1'b0);
            SEL_D3:  out_o = nz && ((a_i % 5'd3) == 5'd0);
            SEL_D4:  out_o = (a_i[1:0] == 2'b00);
            SEL_D5:  out_o = nz && ((a_i % 5'd5) == 5'd0);
            SEL_D6:  out_o = nz && ((a_i % 5'd6) == 5'd0);
            SEL_D7:  out_o = nz && ((a_i % 5'd7) == 5'd0);
            SEL_D8:  out_o = (a_i[2:0] == 3'b000);
            SEL_D9:  out_o = nz && ((a_i % 5'd9) == 5'd0);
            default: out_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/div_scan_ctrl.sv
// div_scan_ctrl: scans all divisor selects for one operand and returns
// the divisor mask and count over valid/ready handshakes.
module div_scan_ctrl
    import div_pkg::*;
#(
    parameter bit SKIP_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [4:0] in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_mask,
    output logic [3:0] out_count,
    output logic [4:0] out_value,
    output logic       busy
);

    state_e     state_q, state_d;
    logic [4:0] a_q, a_d;
    logic [2:0] sel_q, sel_d;
    logic [7:0] mask_q, mask_d;
    logic [3:0] cnt_q, cnt_d;

    logic       chk;
    logic [7:0] cap;
    logic [7:0] skip;
    logic [7:0] rem;
    logic [2:0] nxt_sel;

    div_check u_check (
        .a_i   (a_q),
        .sel_i (sel_q),
        .out_o (chk)
    );

    // Mask including this cycle's capture, and the selects still to visit
    always_comb begin
        cap  = mask_q | (8'(chk) << sel_q);
        skip = 8'h00;
        if (SKIP_EN) begin
            if (!cap[0]) skip = skip | SKIP_IF_ODD;
            if (!cap[1]) skip = skip | SKIP_IF_NOT3;
        end
        rem     = (8'hFE << sel_q) & ~skip;
        nxt_sel = sel_q;
        for (int i = 7; i >= 0; i--) begin
            if (rem[i]) nxt_sel = 3'(i);
        end
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= 5'd0;
            sel_q   <= 3'd0;
            mask_q  <= 8'h00;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            sel_q   <= sel_d;
            mask_q  <= mask_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and datapath updates
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        sel_d   = sel_q;
        mask_d  = mask_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = SCAN;
                    a_d     = in_data;
                    sel_d   = SEL_D2;
                    mask_d  = 8'h00;
                    cnt_d   = 4'd0;
                end
            end
            SCAN: begin
                mask_d = cap;
                cnt_d  = cnt_q + 4'(chk);
                if (rem != 8'h00) sel_d = nxt_sel;
                else state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == SCAN) || (state_q == DONE);
    assign out_mask  = mask_q;
    assign out_count = cnt_q;
    assign out_value = a_q;

endmodule

// File: tb/tb_div_scan_ctrl.sv
// tb_div_scan_ctrl: randomized and directed check of div_scan_ctrl
// with and without skipping, against a divisibility model.
module tb_div_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [4:0] in_data;
    logic       out_ready;

    logic       ir1, ov1, bz1;
    logic [7:0] om1;
    logic [3:0] oc1;
    logic [4:0] ovl1;
    logic       ir0, ov0, bz0;
    logic [7:0] om0;
    logic [3:0] oc0;
    logic [4:0] ovl0;

    int checks   = 0;
    int failures = 0;
    int exp_a    = 0;
    bit mon_en   = 1'b0;

    always #5 clk = ~clk;

    div_scan_ctrl #(.SKIP_EN(1'b1)) u_skip (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (ir1),
        .in_data   (in_data),
        .out_valid (ov1),
        .out_ready (out_ready),
        .out_mask  (om1),
        .out_count (oc1),
        .out_value (ovl1),
        .busy      (bz1)
    );

    div_scan_ctrl #(.SKIP_EN(1'b0)) u_full (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (ir0),
        .in_data   (in_data),
        .out_valid (ov0),
        .out_ready (out_ready),
        .out_mask  (om0),
        .out_count (oc0),
        .out_value (ovl0),
        .busy      (bz0)
    );

    function automatic int ref_mask(input int a);
        int m = 0;
        for (int k = 0; k < 8; k++) begin
            int d = k + 2;
            bit pow2 = (d == 2) || (d == 4) || (d == 8);
            if ((a % d == 0) && (a != 0 || pow2)) m = m | (1 << k);
        end
        return m;
    endfunction

    function automatic int ref_count(input int a);
        int m = ref_mask(a);
        int c = 0;
        for (int k = 0; k < 8; k++) c += (m >> k) & 1;
        return c;
    endfunction

    function automatic int ref_n(input int a, input bit skip);
        bit even = (a % 2 == 0);
        bit by3  = (a != 0) && (a % 3 == 0);
        if (!skip) return 8;
        if (even && by3) return 8;
        if (even) return 6;
        if (by3) return 5;
        return 4;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Whenever a result is offered it must match the model for the operand
    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            if (ov1) begin
                chk("mon_mask_skip", int'(om1), ref_mask(exp_a));
                chk("mon_cnt_skip", int'(oc1), ref_count(exp_a));
                chk("mon_val_skip", int'(ovl1), exp_a);
                chk("mon_rdy_skip", int'({ir1, bz1}), 1);
            end
            if (ov0) begin
                chk("mon_mask_full", int'(om0), ref_mask(exp_a));
                chk("mon_cnt_full", int'(oc0), ref_count(exp_a));
                chk("mon_val_full", int'(ovl0), exp_a);
                chk("mon_rdy_full", int'({ir0, bz0}), 1);
            end
        end
    end

    task automatic run_op(input int a, input int hold,
                          input bit lit, input int lmask, input int lcnt);
        int n1 = 0;
        int n0 = 0;
        logic [7:0] m_snap;
        @(negedge clk);
        chk("idle_ready", int'({ir1, ir0}), 3);
        in_valid = 1'b1;
        in_data  = 5'(a);
        exp_a    = a;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("busy_after_accept", int'({bz1, bz0, ir1, ir0}), 12);
        for (int t = 1; t <= 20; t++) begin
            @(posedge clk);
            #1;
            if (ov1 && n1 == 0) n1 = t;
            if (ov0 && n0 == 0) n0 = t;
            if (n1 != 0 && n0 != 0) break;
        end
        if (n1 == 0 || n0 == 0) begin
            chk("timeout_out_valid", 0, 1);
            return;
        end
        chk("latency_skip", n1, ref_n(a, 1'b1));
        chk("latency_full", n0, 8);
        chk("mask_match", int'(om1), int'(om0));
        if (lit) begin
            chk("lit_mask", int'(om1), lmask);
            chk("lit_count", int'(oc1), lcnt);
            chk("count_le5", int'(oc1 <= 4'd5), 1);
        end
        m_snap = om1;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            in_valid = (h % 2 == 0);
            in_data  = 5'($urandom_range(0, 31));
            @(posedge clk);
            #1;
            chk("hold_stable", int'({ov1, ir1, om1}), int'({2'b10, m_snap}));
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("exit_idle", int'({ir1, ir0, ov1, ov0, bz1, bz0}), 6'b110000);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 5'd0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", int'({ir1, ov1, om1, oc1, ovl1, bz1}),
            int'({1'b1, 1'b0, 8'h00, 4'd0, 5'd0, 1'b0}));
        rst_n  = 1'b1;
        mon_en = 1'b1;

        run_op(6, 0, 1'b1, 'h13, 3);
        run_op(7, 0, 1'b1, 'h20, 1);
        run_op(1, 0, 1'b1, 'h00, 0);
        run_op(0, 0, 1'b1, 'h45, 3);
        run_op(9, 0, 1'b1, 'h82, 2);
        run_op(24, 0, 1'b1, 'h57, 5);
        run_op(30, 10, 1'b1, 'h1B, 4);

        for (int a = 0; a < 32; a++) run_op(a, 0, 1'b0, 0, 0);
        for (int r = 0; r < 20; r++)
            run_op(int'($urandom_range(0, 31)), int'($urandom_range(0, 3)),
                   1'b0, 0, 0);

        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 5'd24;
        exp_a    = 24;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midscan_reset_skip", int'({ir1, ov1, om1, oc1, ovl1, bz1}),
            int'({1'b1, 1'b0, 8'h00, 4'd0, 5'd0, 1'b0}));
        chk("midscan_reset_full", int'({ir0, ov0, om0, oc0, ovl0, bz0}),
            int'({1'b1, 1'b0, 8'h00, 4'd0, 5'd0, 1'b0}));
        rst_n = 1'b1;
        run_op(5, 0, 1'b1, 'h08, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/div_scan_ctrl.md
# div_scan_ctrl

Sequencer that owns the 5-bit divisibility checker and scans all eight divisor selects for one operand. It accepts a 5-bit value over a valid/ready handshake and steps the checker's select through 0..7, one per cycle. Implied-zero selects are skipped. It returns an 8-bit divisor mask plus a divisor count over a second valid/ready handshake. It sits between operand producers and downstream classification logic, and is the only driver of the checker's select.

## Interface
Parameters:
- SKIP_EN, 1, when 1 skip selects whose result is implied zero; when 0 always evaluate all 8.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  operand offered.
- in_ready  out  1  block accepts operand (high only in IDLE).
- in_data  in  5  operand A.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- out_mask  out  8  bit k = checker result for select k.
- out_count  out  4  popcount of out_mask.
- out_value  out  5  operand the result belongs to.
- busy  out  1  high in SCAN or DONE.

## Operation
- Checker function, select k tests divisor d = k+2:
  - k ∈ {0,2,6} (d = 2, 4, 8): 1 iff A mod d == 0, including A = 0.
  - k ∈ {1,3,4,5,7} (d = 3, 5, 6, 7, 9): 1 iff A ≠ 0 and A mod d == 0.
- FSM states: IDLE, SCAN, DONE.
  - IDLE→SCAN on in_valid & in_ready: latch in_data, sel=0, mask=0, count=0.
  - SCAN: each cycle, capture the checker output into mask[sel] and add it to count. Advance sel to the next non-skipped select. After the last evaluated select, go to DONE.
  - DONE→IDLE on out_ready. Otherwise hold, with outputs stable.
- Skip rules (SKIP_EN=1), decided from already-captured bits:
  - mask[0]==0 → skip selects 2, 4, 6.
  - mask[1]==0 → skip selects 4, 7.
  - Skipped bits remain 0. The resulting mask equals the SKIP_EN=0 mask for every A.
- Evaluated count N ranges from 4 to 8:
  - 8 when mask[0] & mask[1].
  - 6 when mask[0] only.
  - 5 when mask[1] only.
  - 4 otherwise.
- in_valid is ignored outside IDLE. No input buffering.

## Timing
- Reset (rst_n low at an edge) gives: IDLE, in_ready=1, out_valid=0, out_mask=0, out_count=0, out_value=0, busy=0.
- Reset mid-SCAN or in DONE discards the operand and result. State is IDLE the cycle after.
- Accept edge E0 → SCAN. out_valid is high after edge E0+N (latency N cycles). busy is high from E0 to the DONE exit edge.
- DONE with out_ready high at edge Ex → IDLE with in_ready=1 after Ex.
- Back-to-back throughput is one operand per N+2 cycles.
- out_mask, out_count and out_value are registered and constant while out_valid is high.
- out_count never exceeds 5 (maximum for a 5-bit A).

## Structure
- Shared package div_pkg holds:
  - state enum (IDLE, SCAN, DONE).
  - select constants SEL_D2..SEL_D9 (0..7).
  - skip masks SKIP_IF_ODD = 8'b0101_0100 and SKIP_IF_NOT3 = 8'b1001_0000.
- Sub-module div_check: the combinational checker (A[4:0], SEL[2:0] → OUT), instantiated once. Its SEL is driven only by this block's sel register.
- Next-select logic is a priority search over the remaining non-skipped selects.

## Test plan
- A=6, SKIP_EN=1 → mask 0x13, count 3, N=8; out_valid 8 cycles after accept.
- A=7 → mask 0x20, count 1, N=4. A=1 → mask 0x00, count 0, N=4.
- A=0 → mask 0x45, count 3, N=6. A=9 → mask 0x82, count 2, N=5.
- A=24 → 0x57/5. A=30 → 0x1B/4. Hold out_ready low 10 cycles: outputs stable, in_ready=0, in_valid pulses ignored.
- Exhaustive 0..31 against the reference model, SKIP_EN=0 and 1: identical masks and counts; N=8 always when SKIP_EN=0.
- Assert rst_n low in the 3rd SCAN cycle with A=24 → next cycle IDLE, all outputs 0. A new operand A=5 then yields mask 0x08, count 1.
